// File: rtl/operand_entry_if.sv
// Operand-entry bus: raw board inputs in, captured operand pair and status out.
// The front-end is the slave; the board/bench side is the master.
interface operand_entry_if;
  logic [15:0] sw;
  logic        btn_enter;
  logic        btn_clear;
  logic [15:0] num1;
  logic [15:0] num2;
  logic        operands_valid;
  logic [1:0]  phase;

  modport master (
    output sw,
    output btn_enter,
    output btn_clear,
    input  num1,
    input  num2,
    input  operands_valid,
    input  phase
  );

  modport slave (
    input  sw,
    input  btn_enter,
    input  btn_clear,
    output num1,
    output num2,
    output operands_valid,
    output phase
  );
endinterface

// File: rtl/operand_entry.sv
// Switch/button front-end: synchronizes raw inputs, debounces and edge-detects
// the buttons, and sequences capture of an operand pair (num1, then num2).
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic           clk,
  input  logic           rst,
  operand_entry_if.slave bus
);

  localparam int SW_W      = 16;
  localparam int N_BTN     = 2;
  localparam int SYNC_W    = SW_W + N_BTN;
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    READY   = 2'b10,
    ILLEGAL = 2'b11
  } phase_t;

  // Button bits sit above the switches so one synchronizer covers every raw input.
  logic [SYNC_W-1:0] raw_in;
  logic [SYNC_W-1:0] sync1_reg;
  logic [SYNC_W-1:0] sync2_reg;
  logic [SW_W-1:0]   sw_sync;
  logic              btn_pulse [N_BTN];
  logic              enter_pulse;
  logic              clear_pulse;

  assign raw_in  = {bus.btn_clear, bus.btn_enter, bus.sw};
  assign sw_sync = sync2_reg[SW_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic             btn_sync;
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             pulse_reg;

      assign btn_sync      = sync2_reg[SW_W + gi];
      assign btn_pulse[gi] = pulse_reg;

      // The pulse is raised on the same edge the level rises, so it is
      // visible in the first cycle of the new debounced level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          if (btn_sync == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= btn_sync;
            pulse_reg <= btn_sync;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  assign enter_pulse = btn_pulse[BTN_ENTER];
  assign clear_pulse = btn_pulse[BTN_CLEAR];

  phase_t          state_reg;
  logic [SW_W-1:0] num1_reg;
  logic [SW_W-1:0] num2_reg;
  logic            valid_reg;

  // Clear takes priority over a coincident enter; the unused encoding
  // recovers to WAIT_A on the next edge whether or not a pulse is present.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= WAIT_A;
      num1_reg  <= '0;
      num2_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (clear_pulse) begin
      state_reg <= WAIT_A;
      num1_reg  <= '0;
      num2_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_A: begin
          if (enter_pulse) begin
            num1_reg  <= sw_sync;
            state_reg <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_pulse) begin
            num2_reg  <= sw_sync;
            valid_reg <= 1'b1;
            state_reg <= READY;
          end
        end
        READY: begin
          if (enter_pulse) begin
            valid_reg <= 1'b0;
            state_reg <= WAIT_A;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= WAIT_A;
        end
      endcase
    end
  end

  assign bus.num1           = num1_reg;
  assign bus.num2           = num2_reg;
  assign bus.operands_valid = valid_reg;
  assign bus.phase          = state_reg;

endmodule
